// File: rtl/mult_div_pkg.sv
// Shared types for the multiply/divide arithmetic stage: sequencer states,
// operation codes and the radix-4 Booth digit encoding.
package mult_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL     = 3'd1,
    ST_DIV     = 3'd2,
    ST_DIV_FIX = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Bit 2 is the negate flag, bits 1:0 the magnitude (0, 1 or 2).
  typedef enum logic [2:0] {
    BD_ZERO = 3'b000,
    BD_P1   = 3'b001,
    BD_P2   = 3'b010,
    BD_M1   = 3'b101,
    BD_M2   = 3'b110
  } booth_t;

endpackage

// File: rtl/mult_div_core_booth_recode_2.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b(2i+1), b(2i), b(2i-1)}
// to a digit magnitude select and a negate flag.
module booth_recode_2
  import mult_div_pkg::*;
(
  input  logic [2:0] win,
  output logic [1:0] sel,
  output logic       neg
);

  booth_t     digit_s;
  logic [2:0] code_s;

  // Window to digit lookup
  always_comb begin
    digit_s = BD_ZERO;
    case (win)
      3'b000, 3'b111: digit_s = BD_ZERO;
      3'b001, 3'b010: digit_s = BD_P1;
      3'b011:         digit_s = BD_P2;
      3'b100:         digit_s = BD_M2;
      3'b101, 3'b110: digit_s = BD_M1;
      default:        digit_s = BD_ZERO;
    endcase
  end

  assign code_s = digit_s;
  assign sel    = code_s[1:0];
  assign neg    = code_s[2];

endmodule

// File: rtl/mult_div_core.sv
// Word-level signed multiply (radix-4 Booth) / restoring divide stage with a
// BUSY/DONE handshake; results hold until the next operation completes.
module mult_div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RES_HI,
  output logic [WIDTH-1:0] RES_LO,
  output logic             OVF
);

  localparam int W  = WIDTH;
  localparam int AW = 2 * W + 2;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(W / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_t         state_r;
  logic [CW-1:0]  step_r;
  logic [W-1:0]   opa_r;
  logic [W-1:0]   opb_r;
  logic [AW-1:0]  acc_r;
  logic           prev_r;
  logic [W-1:0]   rem_r;
  logic [W-1:0]   quo_r;
  logic [W-1:0]   dvs_r;
  logic           busy_r;
  logic           done_r;
  logic [W-1:0]   res_hi_r;
  logic [W-1:0]   res_lo_r;
  logic           ovf_r;

  logic           accept_s;
  logic [2:0]     win_s;
  logic [1:0]     sel_s;
  logic           neg_s;
  logic [W+1:0]   mcand_s;
  logic [W+1:0]   pp_mag_s;
  logic [W+1:0]   pp_s;
  logic [W+1:0]   hi_sum_s;
  logic [AW-1:0]  acc_nxt_s;
  logic [W-1:0]   opa_mag_s;
  logic [W-1:0]   opb_mag_s;
  logic [W:0]     shift_s;
  logic           fits_s;
  logic [W-1:0]   rem_nxt_s;
  logic [W-1:0]   q_fix_s;
  logic [W-1:0]   r_fix_s;
  logic           ovf_fix_s;

  assign accept_s = START && ((state_r == ST_IDLE) || (state_r == ST_FIN));

  assign win_s   = {acc_r[1:0], prev_r};
  assign mcand_s = {{2{opa_r[W-1]}}, opa_r};

  booth_recode_2 u_booth (
    .win (win_s),
    .sel (sel_s),
    .neg (neg_s)
  );

  // Booth partial product for the current step
  always_comb begin
    pp_mag_s = {(W+2){1'b0}};
    case (sel_s)
      2'd1:    pp_mag_s = mcand_s;
      2'd2:    pp_mag_s = {mcand_s[W:0], 1'b0};
      default: pp_mag_s = {(W+2){1'b0}};
    endcase
    if (neg_s) begin
      pp_s = ~pp_mag_s + (W+2)'(1);
    end else begin
      pp_s = pp_mag_s;
    end
  end

  assign hi_sum_s  = acc_r[AW-1:W] + pp_s;
  assign acc_nxt_s = {{2{hi_sum_s[W+1]}}, hi_sum_s, acc_r[W-1:2]};

  // Operand magnitudes; |most negative| still fits W unsigned bits
  always_comb begin
    if (OPA[W-1]) begin
      opa_mag_s = ~OPA + W'(1);
    end else begin
      opa_mag_s = OPA;
    end
    if (OPB[W-1]) begin
      opb_mag_s = ~OPB + W'(1);
    end else begin
      opb_mag_s = OPB;
    end
  end

  // Remainder stays below the divisor, so W bits hold it between steps
  assign shift_s   = {rem_r, quo_r[W-1]};
  assign fits_s    = (shift_s >= {1'b0, dvs_r});
  assign rem_nxt_s = shift_s[W-1:0] - dvs_r;

  // Sign correction applied in the DIV_FIX cycle
  always_comb begin
    if (opa_r[W-1] ^ opb_r[W-1]) begin
      q_fix_s = ~quo_r + W'(1);
    end else begin
      q_fix_s = quo_r;
    end
    if (opb_r[W-1]) begin
      r_fix_s = ~rem_r + W'(1);
    end else begin
      r_fix_s = rem_r;
    end
    ovf_fix_s = (opb_r == MOST_NEG) && (opa_r == {W{1'b1}});
  end

  // Sequencer, datapath registers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      step_r   <= {CW{1'b0}};
      opa_r    <= {W{1'b0}};
      opb_r    <= {W{1'b0}};
      acc_r    <= {AW{1'b0}};
      prev_r   <= 1'b0;
      rem_r    <= {W{1'b0}};
      quo_r    <= {W{1'b0}};
      dvs_r    <= {W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      res_hi_r <= {W{1'b0}};
      res_lo_r <= {W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_FIN: begin
          if (accept_s) begin
            opa_r   <= OPA;
            opb_r   <= OPB;
            acc_r   <= {{(W+2){1'b0}}, OPB};
            prev_r  <= 1'b0;
            rem_r   <= {W{1'b0}};
            quo_r   <= opb_mag_s;
            dvs_r   <= opa_mag_s;
            step_r  <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= (OP == OP_DIV) ? ST_DIV : ST_MUL;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc_r  <= acc_nxt_s;
          prev_r <= acc_r[1];
          if (step_r == MUL_LAST) begin
            res_hi_r <= acc_nxt_s[2*W-1:W];
            res_lo_r <= acc_nxt_s[W-1:0];
            ovf_r    <= 1'b0;
            step_r   <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_FIN;
          end else begin
            step_r <= step_r + CW'(1);
          end
        end
        ST_DIV: begin
          if (dvs_r == {W{1'b0}}) begin
            res_hi_r <= opb_r;
            res_lo_r <= {W{1'b0}};
            ovf_r    <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_FIN;
          end else begin
            if (fits_s) begin
              rem_r <= rem_nxt_s;
              quo_r <= {quo_r[W-2:0], 1'b1};
            end else begin
              rem_r <= shift_s[W-1:0];
              quo_r <= {quo_r[W-2:0], 1'b0};
            end
            if (step_r == DIV_LAST) begin
              step_r  <= {CW{1'b0}};
              state_r <= ST_DIV_FIX;
            end else begin
              step_r <= step_r + CW'(1);
            end
          end
        end
        ST_DIV_FIX: begin
          res_hi_r <= r_fix_s;
          res_lo_r <= q_fix_s;
          ovf_r    <= ovf_fix_s;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= ST_FIN;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RES_HI = res_hi_r;
  assign RES_LO = res_lo_r;
  assign OVF    = ovf_r;

endmodule

// File: tb/tb_mult_div_core.sv
// Self-checking bench for mult_div_core: directed cases with literal results,
// then random traffic compared every cycle against an arithmetic model.
module tb_mult_div_core;

  localparam int W = 26;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         OP = 1'b0;
  logic [W-1:0] OPA = '0;
  logic [W-1:0] OPB = '0;
  logic         BUSY, DONE, OVF;
  logic [W-1:0] RES_HI, RES_LO;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mult_div_core #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .BUSY(BUSY), .DONE(DONE), .RES_HI(RES_HI), .RES_LO(RES_LO), .OVF(OVF)
  );

  // ---------------- behavioural model ----------------
  // Result packed as {ovf, hi, lo}.
  function automatic logic [2*W:0] model_res(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 1'b0) begin
      p = sa * sb;
      return {1'b0, p[2*W-1:0]};
    end
    if (sa == 0) return {1'b1, b, {W{1'b0}}};
    q = sb / sa;
    r = sb % sa;
    ovf = (b == MOST_NEG) && (sa == -1);
    return {ovf, r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int model_lat(input logic op, input logic [W-1:0] a);
    if (op == 1'b0) return W / 2 + 1;
    if (a == '0) return 2;
    return W + 2;
  endfunction

  bit           m_active = 1'b0;
  int           m_age = 0;
  int           m_lat = 0;
  logic [2*W:0] p_res = '0;
  logic [2*W:0] exp_res = '0;
  logic         exp_busy, exp_done;

  assign exp_busy = m_active && (m_age < m_lat);
  assign exp_done = m_active && (m_age == m_lat);

  // Model: age of the current operation in cycles since acceptance
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_lat    <= 0;
      exp_res  <= '0;
    end else if ((!m_active || m_age == m_lat) && START) begin
      m_active <= 1'b1;
      m_age    <= 1;
      m_lat    <= model_lat(OP, OPA);
      p_res    <= model_res(OP, OPA, OPB);
    end else if (m_active) begin
      if (m_age == m_lat) begin
        m_active <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 == m_lat) exp_res <= p_res;
      end
    end
  end

  task automatic chk(input string nm, input logic [2*W:0] got, input logic [2*W:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    chk("cyc_busy", {52'd0, BUSY}, {52'd0, exp_busy});
    chk("cyc_done", {52'd0, DONE}, {52'd0, exp_done});
    chk("cyc_res", {OVF, RES_HI, RES_LO}, exp_res);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input int n0, output int n);
    bit seen;
    seen = 1'b0;
    n = n0;
    while (!seen && n < 200) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen = 1'b1;
      else begin
        @(posedge CLK); #1;
        n++;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no DONE expected DONE within 200 cycles");
    end
  endtask

  task automatic run_check(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int elat, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                           input logic eovf, input string nm);
    int n;
    @(posedge CLK); #1;
    START = 1'b1; OP = op; OPA = a; OPB = b;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(1, n);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_hi"}, {27'd0, RES_HI}, {27'd0, ehi});
    chk({nm, "_lo"}, {27'd0, RES_LO}, {27'd0, elo});
    chk({nm, "_ovf"}, {52'd0, OVF}, {52'd0, eovf});
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return W'(1);
      2:       return {W{1'b1}};
      3:       return MOST_NEG;
      4:       return ~MOST_NEG;
      5:       return W'($urandom_range(0, 15));
      default: return t[W-1:0];
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int dcount;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {52'd0, BUSY}, '0);
    chk("rst_done", {52'd0, DONE}, '0);
    chk("rst_res", {OVF, RES_HI, RES_LO}, '0);
    RST = 1'b0;

    // Pin the model to hand-computed values
    chk("model_mul", model_res(1'b0, 26'd3, 26'd5), {1'b0, 26'd0, 26'd15});
    chk("model_div", model_res(1'b1, 26'd2, 26'h3FFFFF9), {1'b0, 26'h3FFFFFF, 26'h3FFFFFD});
    chk("model_dmin", model_res(1'b1, 26'h3FFFFFF, 26'h2000000), {1'b1, 26'd0, 26'h2000000});

    run_check(1'b0, 26'd3, 26'd5, 14, 26'd0, 26'd15, 1'b0, "mul_3x5");
    run_check(1'b0, 26'h3FFFFFF, 26'd1, 14, 26'h3FFFFFF, 26'h3FFFFFF, 1'b0, "mul_m1x1");
    run_check(1'b0, 26'h2000000, 26'h2000000, 14, 26'h1000000, 26'd0, 1'b0, "mul_minxmin");
    run_check(1'b1, 26'd2, 26'h3FFFFF9, 28, 26'h3FFFFFF, 26'h3FFFFFD, 1'b0, "div_m7_2");
    run_check(1'b1, 26'd0, 26'd100, 2, 26'd100, 26'd0, 1'b1, "div_by0");
    run_check(1'b1, 26'h3FFFFFF, 26'h2000000, 28, 26'd0, 26'h2000000, 1'b1, "div_min_m1");

    // START while busy is ignored; START in FIN launches back-to-back
    @(posedge CLK); #1;
    START = 1'b1; OP = 1'b0; OPA = 26'd3; OPB = 26'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    START = 1'b1; OP = 1'b1; OPA = 26'd7; OPB = 26'd9;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(6, n);
    chk("ign_lat", n, 14);
    chk("ign_lo", {27'd0, RES_LO}, {27'd0, 26'd15});
    chk("ign_hi", {27'd0, RES_HI}, '0);
    START = 1'b1; OP = 1'b1; OPA = 26'd2; OPB = 26'h3FFFFF9;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(1, n);
    chk("b2b_lat", n, 28);
    chk("b2b_lo", {27'd0, RES_LO}, {27'd0, 26'h3FFFFFD});
    chk("b2b_hi", {27'd0, RES_HI}, {27'd0, 26'h3FFFFFF});

    // Reset in cycle 7 of a divide
    @(posedge CLK); #1;
    START = 1'b1; OP = 1'b1; OPA = 26'd7; OPB = 26'd1000;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (6) begin @(posedge CLK); #1; end
    RST = 1'b1;
    #1;
    chk("arst_busy", {52'd0, BUSY}, '0);
    chk("arst_done", {52'd0, DONE}, '0);
    chk("arst_res", {OVF, RES_HI, RES_LO}, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_check(1'b1, 26'd7, 26'd1000, 28, 26'd6, 26'd142, 1'b0, "div_after_rst");

    // Random traffic, including START while busy and rare resets
    for (int c = 0; c < 6000; c++) begin
      @(posedge CLK); #1;
      if ($urandom_range(0, 1499) == 0) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
      end
      START = ($urandom_range(0, 99) < 30);
      OP    = 1'($urandom_range(0, 1));
      OPA   = rand_operand();
      OPB   = rand_operand();
    end
    START = 1'b0;
    repeat (40) @(posedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
